// File: rtl/reg_bank_pkg.sv
// Shared constants, register-mode encoding and mask decode for the register bank.
package reg_bank_pkg;

  localparam int DataW = 32;
  localparam int BeW   = 4;

  typedef enum logic [1:0] {
    RegRW  = 2'd0,
    RegRO  = 2'd1,
    RegW1C = 2'd2
  } reg_mode_e;

  // Read-only takes precedence; the masks are not expected to overlap.
  function automatic reg_mode_e reg_mode_of(input logic [31:0] ro_mask,
                                            input logic [31:0] w1c_mask,
                                            input int          idx);
    if (ro_mask[idx]) begin
      return RegRO;
    end else if (w1c_mask[idx]) begin
      return RegW1C;
    end else begin
      return RegRW;
    end
  endfunction

endpackage

// File: rtl/reg_bank_word.sv
// One 32-bit register: byte-enabled write (RW), write-1-to-clear with hardware set (W1C),
// or a pass-through of hardware status (RO). Emits a one-cycle write strobe.
module reg_bank_word
  import reg_bank_pkg::*;
#(
  parameter reg_mode_e         Mode     = RegRW,
  parameter logic [DataW-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [BeW-1:0]   be_i,
  input  logic [DataW-1:0] hw_status_i,
  input  logic [DataW-1:0] hw_set_i,
  output logic [DataW-1:0] q_o,
  output logic             qe_o
);

  logic [DataW-1:0] value_r;
  logic [DataW-1:0] next_s;
  logic [DataW-1:0] bmask_s;
  logic             qe_r;
  logic             unused_s;

  // Expand byte enables into a per-bit mask.
  always_comb begin
    bmask_s = '0;
    for (int b = 0; b < BeW; b++) begin
      bmask_s[b*8 +: 8] = {8{be_i[b]}};
    end
  end

  // Next stored value; for W1C the hardware set is applied last so it wins over a clear.
  always_comb begin
    next_s = value_r;
    case (Mode)
      RegRW: begin
        if (we_i) begin
          next_s = (value_r & ~bmask_s) | (wdata_i & bmask_s);
        end else begin
          next_s = value_r;
        end
      end
      RegW1C: begin
        if (we_i) begin
          next_s = (value_r & ~(wdata_i & bmask_s)) | hw_set_i;
        end else begin
          next_s = value_r | hw_set_i;
        end
      end
      default: next_s = value_r;
    endcase
  end

  // Storage and write strobe; RO registers never strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_r <= ResetVal;
      qe_r    <= 1'b0;
    end else begin
      value_r <= next_s;
      qe_r    <= we_i && (Mode != RegRO);
    end
  end

  assign q_o      = (Mode == RegRO) ? hw_status_i : value_r;
  assign qe_o     = qe_r;
  assign unused_s = ^{hw_status_i, hw_set_i};

endmodule

// File: rtl/reg_bank.sv
// Parametrised memory-mapped register bank with single-entry response register,
// decode-error responses, per-register write strobes and a W1C event interrupt.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                         NumRegs  = 4,
  parameter int                         AW       = 7,
  parameter logic [NumRegs-1:0]         RoMask   = '0,
  parameter logic [NumRegs-1:0]         W1cMask  = '0,
  parameter logic [NumRegs*DataW-1:0]   ResetVal = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [AW-1:0]              req_addr_i,
  input  logic [DataW-1:0]           req_wdata_i,
  input  logic [BeW-1:0]             req_be_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DataW-1:0]           rsp_rdata_o,
  output logic                       rsp_err_o,
  input  logic [NumRegs*DataW-1:0]   hw_status_i,
  input  logic [NumRegs*DataW-1:0]   hw_set_i,
  output logic [NumRegs*DataW-1:0]   reg_q_o,
  output logic [NumRegs-1:0]         reg_qe_o,
  output logic                       irq_o
);

  localparam int                IdxW       = AW - 2;
  localparam logic [31:0]       RoMaskExt  = 32'(RoMask);
  localparam logic [31:0]       W1cMaskExt = 32'(W1cMask);
  localparam logic [IdxW:0]     NumRegsW   = (IdxW + 1)'(NumRegs);

  logic [IdxW-1:0]            index_s;
  logic                       dec_err_s;
  logic                       ready_s;
  logic                       accept_s;
  logic [NumRegs-1:0]         wr_en_s;
  logic [NumRegs*DataW-1:0]   q_s;
  logic [DataW-1:0]           rd_s;
  logic                       irq_s;
  logic                       rsp_valid_r;
  logic [DataW-1:0]           rsp_rdata_r;
  logic                       rsp_err_r;
  logic                       unused_s;

  assign index_s   = req_addr_i[AW-1:2];
  assign dec_err_s = ({1'b0, index_s} >= NumRegsW);
  assign ready_s   = !rst_i && (!rsp_valid_r || rsp_ready_i);
  assign accept_s  = req_valid_i && ready_s;

  for (genvar i = 0; i < NumRegs; i++) begin : g_word
    localparam reg_mode_e Mode = reg_mode_of(RoMaskExt, W1cMaskExt, i);

    assign wr_en_s[i] = accept_s && req_we_i && !dec_err_s && (index_s == IdxW'(i));

    reg_bank_word #(
      .Mode     (Mode),
      .ResetVal (ResetVal[i*DataW +: DataW])
    ) u_word (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .we_i        (wr_en_s[i]),
      .wdata_i     (req_wdata_i),
      .be_i        (req_be_i),
      .hw_status_i (hw_status_i[i*DataW +: DataW]),
      .hw_set_i    (hw_set_i[i*DataW +: DataW]),
      .q_o         (q_s[i*DataW +: DataW]),
      .qe_o        (reg_qe_o[i])
    );
  end

  // Read mux over current register values; out-of-range indices select nothing.
  always_comb begin
    rd_s = '0;
    for (int i = 0; i < NumRegs; i++) begin
      rd_s = rd_s | ((index_s == IdxW'(i)) ? q_s[i*DataW +: DataW] : {DataW{1'b0}});
    end
  end

  // Interrupt is the OR of every bit held in W1C registers.
  always_comb begin
    irq_s = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      irq_s = irq_s | ((reg_mode_of(RoMaskExt, W1cMaskExt, i) == RegW1C) && (|q_s[i*DataW +: DataW]));
    end
  end

  // Single held response: loaded on acceptance, dropped on consumption or reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= dec_err_s;
      rsp_rdata_r <= (req_we_i || dec_err_s) ? {DataW{1'b0}} : rd_s;
    end else if (rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req_ready_o = ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = rsp_rdata_r;
  assign rsp_err_o   = rsp_err_r;
  assign reg_q_o     = q_s;
  assign irq_o       = irq_s;
  assign unused_s    = ^req_addr_i[1:0];

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: reference model of register semantics pushes expected
// responses; a monitor pops them on each response handshake and checks bank state each cycle.
module tb_reg_bank;

  localparam int NR = 4;
  localparam int AWT = 7;
  localparam logic [NR-1:0]    RO_MASK   = 4'b1000;
  localparam logic [NR-1:0]    W1C_MASK  = 4'b0100;
  localparam logic [NR*32-1:0] RESET_VAL = {32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF};

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_we;
  logic [AWT-1:0]    req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [NR*32-1:0]  hw_status, hw_set, reg_q;
  logic [NR-1:0]     reg_qe;
  logic              irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_until = 0;
  bit rand_ready = 1'b0;

  logic [31:0] m_reg [NR];
  logic        m_held = 1'b0;
  logic        m_acc = 1'b0;
  logic [NR-1:0] m_qe = '0;
  logic [32:0] exp_q [$];

  reg_bank #(
    .NumRegs (NR), .AW (AWT), .RoMask (RO_MASK), .W1cMask (W1C_MASK), .ResetVal (RESET_VAL)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .req_valid_i (req_valid), .req_ready_o (req_ready), .req_we_i (req_we),
    .req_addr_i (req_addr), .req_wdata_i (req_wdata), .req_be_i (req_be),
    .rsp_valid_o (rsp_valid), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata), .rsp_err_o (rsp_err),
    .hw_status_i (hw_status), .hw_set_i (hw_set),
    .reg_q_o (reg_q), .reg_qe_o (reg_qe), .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response back-pressure and hardware status are driven on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cyc <= stall_until) rsp_ready = 1'b0;
    else if (rand_ready)    rsp_ready = ($urandom_range(0, 3) != 0);
    else                    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) hw_status[i*32 +: 32] = $urandom;
  end

  // Reference model: register semantics written bit by bit from the rules.
  always @(posedge clk or posedge rst) begin : model_blk
    logic [31:0] nv [NR];
    logic [NR-1:0] qe;
    logic acc;
    int idx;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_reg[i] <= RESET_VAL[i*32 +: 32];
      m_held <= 1'b0;
      m_acc  <= 1'b0;
      m_qe   <= '0;
      exp_q.delete();
    end else begin
      acc = req_valid && (!m_held || rsp_ready);
      idx = int'(req_addr[AWT-1:2]);
      qe  = '0;
      for (int i = 0; i < NR; i++) nv[i] = m_reg[i];
      if (acc) begin
        if (idx >= NR) begin
          exp_q.push_back({1'b1, 32'h0});
        end else if (!req_we) begin
          exp_q.push_back({1'b0, RO_MASK[idx] ? hw_status[idx*32 +: 32] : m_reg[idx]});
        end else begin
          exp_q.push_back({1'b0, 32'h0});
          if (!RO_MASK[idx]) begin
            qe[idx] = 1'b1;
            for (int b = 0; b < 32; b++) begin
              if (req_be[b/8]) begin
                if (W1C_MASK[idx]) begin
                  if (req_wdata[b]) nv[idx][b] = 1'b0;
                end else begin
                  nv[idx][b] = req_wdata[b];
                end
              end
            end
          end
        end
      end
      for (int i = 0; i < NR; i++)
        if (W1C_MASK[i])
          for (int b = 0; b < 32; b++)
            if (hw_set[i*32 + b]) nv[i][b] = 1'b1;
      m_reg  <= nv;
      m_qe   <= qe;
      m_acc  <= acc;
      m_held <= acc ? 1'b1 : (rsp_ready ? 1'b0 : m_held);
    end
  end

  // Monitor: per-cycle state checks and scoreboard pop on each response handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    logic exp_irq;
    #1;
    chk("req_ready", 64'(req_ready), 64'(!rst && (!m_held || rsp_ready)));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_held));
    chk("reg_qe", 64'(reg_qe), 64'(m_qe));
    exp_irq = 1'b0;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("reg_q%0d", i), 64'(reg_q[i*32 +: 32]),
          64'(RO_MASK[i] ? hw_status[i*32 +: 32] : m_reg[i]));
      if (W1C_MASK[i]) exp_irq = exp_irq | (|m_reg[i]);
    end
    chk("irq", 64'(irq), 64'(exp_irq));
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rsp", 64'({rsp_err, rsp_rdata}), 64'(e));
      end
    end
  end

  task automatic send(input logic we, input logic [AWT-1:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_acc && n < 50);
    chk("send_accept", 64'(m_acc), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    hw_set = '0; hw_status = '0; rsp_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(1'b0, 7'h04, 32'h0, 4'h0);
    send(1'b1, 7'h00, 32'hFFFF_FFFF, 4'hF);
    send(1'b1, 7'h00, 32'hAABB_CCDD, 4'b0101);
    send(1'b0, 7'h00, 32'h0, 4'h0);

    send(1'b1, 7'h08, 32'h0000_0001, 4'hF);
    hw_set[2*32 + 3] = 1'b1;
    @(negedge clk);
    hw_set = '0;
    @(negedge clk);
    hw_set[2*32 + 3] = 1'b1;
    send(1'b1, 7'h08, 32'h0000_0008, 4'hF);
    hw_set = '0;
    send(1'b1, 7'h08, 32'h0000_0008, 4'hF);

    send(1'b0, 7'h10, 32'h0, 4'h0);
    send(1'b1, 7'h10, 32'h5555_AAAA, 4'hF);
    send(1'b1, 7'h7C, 32'h1111_2222, 4'hF);
    send(1'b1, 7'h04, 32'hCAFE_F00D, 4'h0);
    send(1'b1, 7'h0C, 32'h0BAD_0BAD, 4'hF);
    send(1'b0, 7'h0C, 32'h0, 4'h0);
    send(1'b1, 7'h04, 32'h0000_0000, 4'hF);
    send(1'b0, 7'h04, 32'h0, 4'h0);

    @(posedge clk); #1;
    stall_until = cyc + 4;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(1'b0, 7'(i * 4), 32'h0, 4'h0);

    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NR; i++) hw_set[i*32 +: 32] = $urandom;
      hw_set[2*32 +: 32] = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send(1'($urandom_range(0, 1)), {5'($urandom_range(0, 5)), 2'($urandom)}, $urandom,
           ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom));
    end
    hw_set = '0;
    rand_ready = 1'b0;

    @(posedge clk); #1;
    stall_until = cyc + 10;
    @(negedge clk);
    send(1'b1, 7'h00, 32'h0123_4567, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stall_until = 0;
    @(negedge clk);
    send(1'b0, 7'h00, 32'h0, 4'h0);
    send(1'b0, 7'h08, 32'h0, 4'h0);

    repeat (5) @(negedge clk);
    #2;
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
